// File: rtl/sm3_msg_if.sv
// Message port between a message source and the SM3 padder input.
// A beat transfers on a rising clk edge with vld=1 and rdy=1; while vld=1 and rdy=0 the source
// holds d/bvld/lst stable and keeps vld high; rdy carries no meaning while vld=0.
interface sm3_msg_if #(
    parameter int DW = 32
);
    logic [DW-1:0]   msg_inpt_d;
    logic            msg_inpt_vld;
    logic [DW/8-1:0] msg_inpt_bvld;
    logic            msg_inpt_lst;
    logic            msg_inpt_rdy;

    modport master (
        output msg_inpt_d, msg_inpt_vld, msg_inpt_bvld, msg_inpt_lst,
        input  msg_inpt_rdy
    );
    modport slave (
        input  msg_inpt_d, msg_inpt_vld, msg_inpt_bvld, msg_inpt_lst,
        output msg_inpt_rdy
    );
endinterface

// File: rtl/sm3_msg_drvr.sv
// Deterministic message source for the SM3 padder input: streams a programmable-length
// message (incrementing bytes or LFSR words) over the valid/ready message port.
module sm3_msg_drvr #(
    parameter int DW    = 32,
    parameter int LEN_W = 16,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len_byte,
    input  logic             pttrn_sel,
    input  logic [31:0]      seed,
    input  logic [GAP_W-1:0] gap_cyc,
    sm3_msg_if.master        msg,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);
    localparam int NB = DW / 8;
    localparam logic [LEN_W-1:0] NB_L = LEN_W'(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0] rem_q;      // bytes of the message not yet accepted
    logic [7:0]       byte_q;     // incrementing-pattern value of the current beat's first byte
    logic [31:0]      lfsr_q;
    logic             pttrn_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt_q;

    logic             accept;
    logic             final_beat;
    logic [LEN_W-1:0] n_valid;
    logic [31:0]      lfsr_nxt;
    logic [31:0]      lfsr_adv;
    logic [DW-1:0]    lfsr_word;
    logic [DW-1:0]    inc_word;
    logic [DW-1:0]    lane_mask;
    logic [DW-1:0]    beat_word;
    logic [NB-1:0]    lane_bvld;

    // Multiply the state by x modulo x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0000_0000);
    endfunction

    assign lfsr_nxt = lfsr_step(lfsr_q);

    generate
        if (DW == 64) begin : g_dw64
            assign lfsr_word = {lfsr_q, lfsr_nxt};
            assign lfsr_adv  = lfsr_step(lfsr_nxt);
        end else begin : g_dw32
            assign lfsr_word = lfsr_q;
            assign lfsr_adv  = lfsr_nxt;
        end
    endgenerate

    assign final_beat = (rem_q <= NB_L);
    assign n_valid    = final_beat ? rem_q : NB_L;
    assign accept     = (state_q == SEND) && msg.msg_inpt_rdy;

    // Lane 0 is the MSB byte; lanes past the message end are zeroed.
    always_comb begin
        inc_word  = '0;
        lane_mask = '0;
        lane_bvld = '0;
        for (int i = 0; i < NB; i++) begin
            inc_word[DW-1-8*i -: 8] = byte_q + 8'(i);
            if (LEN_W'(i) < n_valid) begin
                lane_bvld[NB-1-i]        = 1'b1;
                lane_mask[DW-1-8*i -: 8] = 8'hFF;
            end
        end
        beat_word = (pttrn_q ? lfsr_word : inc_word) & lane_mask;
    end

    always_comb begin
        state_d           = state_q;
        msg.msg_inpt_vld  = 1'b0;
        msg.msg_inpt_d    = '0;
        msg.msg_inpt_bvld = '0;
        msg.msg_inpt_lst  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (msg_len_byte == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                msg.msg_inpt_vld  = 1'b1;
                msg.msg_inpt_d    = beat_word;
                msg.msg_inpt_bvld = lane_bvld;
                msg.msg_inpt_lst  = final_beat;
                if (msg.msg_inpt_rdy) begin
                    if (final_beat) begin
                        state_d = FIN;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = SEND;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            byte_q    <= '0;
            lfsr_q    <= '0;
            pttrn_q   <= 1'b0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                rem_q   <= msg_len_byte;
                byte_q  <= seed[7:0];
                lfsr_q  <= (seed == '0) ? 32'h0000_0001 : seed;
                pttrn_q <= pttrn_sel;
                gap_q   <= gap_cyc;
            end
            if (accept) begin
                rem_q  <= final_beat ? '0 : rem_q - NB_L;
                byte_q <= byte_q + 8'(NB);
                lfsr_q <= lfsr_adv;
                if (!final_beat && gap_q != '0) begin
                    gap_cnt_q <= gap_q - GAP_W'(1);
                end
            end
            if (state_q == GAP && gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign dbg_state = state_q;
endmodule

// File: doc/sm3_msg_drvr.md
Name: sm3_msg_drvr

Overview:
Synthesizable message source that drives the SM3 padding input interface (the transmit end of the padder's message port).
- On a start pulse it generates a message of programmable byte length from a deterministic pattern.
- It streams the message with a valid/ready handshake, a last flag and byte-valid marking on the final beat.
- Used in regression benches and on-FPGA self-test, so that padding/compression results can be checked against precomputed golden blocks.

Parameters:
DW, 32, input data width in bits; only 32 or 64 are legal, matching the SM3_INPT_DW_32/SM3_INPT_DW_64 configurations
LEN_W, 16, width of the message byte-length field
GAP_W, 4, width of the inter-beat gap field

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a message; ignored while busy=1
msg_len_byte  in  LEN_W  message length in bytes, sampled on an accepted start
pttrn_sel  in  1  data pattern: 0 = incrementing bytes, 1 = LFSR words; sampled on start
seed  in  32  pattern seed, sampled on start
gap_cyc  in  GAP_W  idle cycles inserted after each accepted beat (0 = back-to-back); sampled on start
msg_inpt_d  out  DW  message data, big-endian (first byte in the MSBs)
msg_inpt_vld  out  1  data valid
msg_inpt_bvld  out  DW/8  byte valid, MSB-first thermometer code
msg_inpt_lst  out  1  marks the final beat of the message
msg_inpt_rdy  in  1  downstream ready
busy  out  1  message in progress
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
Reset:
- All outputs are 0 and the FSM is in IDLE.
- Reset asserted mid-message aborts immediately: no done, and no residual vld after reset release.

FSM states: IDLE, SEND, GAP, FIN.
- IDLE: on start, latch all inputs, compute beats = ceil(len/(DW/8)), and set busy=1 in the next cycle.
  - len=0: go to FIN; no beat is issued.
  - len>0: go to SEND.
- SEND: vld=1.
  - On vld&rdy with the final beat: go to FIN.
  - On vld&rdy, not final, gap_cyc>0: go to GAP.
  - Otherwise remain in SEND and present the next beat in the following cycle.
- GAP: vld=0; count gap_cyc cycles, then return to SEND.
- FIN: done=1 for exactly one cycle, busy falls in the same cycle, then go to IDLE.
  - A start arriving in FIN is ignored.
  - A start in the IDLE cycle that follows FIN is accepted.
- Cycle latency: start accepted at cycle N gives first vld at N+1 and busy at N+1. Zero-length message gives done at N+1.

Handshake:
- While vld=1 and rdy=0, d, bvld and lst are held stable.
- vld never drops without acceptance.
- rdy is ignored when vld=0.

Byte count and bvld:
- Remaining bytes r = len - (beat_idx × DW/8).
- Non-final beats: bvld all ones.
- Final beat: top min(r, DW/8) bits set.
- Invalid byte lanes carry 0.
- lst=1 only on the final beat.

Pattern 0 (incrementing): byte k = (seed[7:0] + k) mod 256, with k counted from message start. Wraps past 0xFF.

Pattern 1 (LFSR):
- 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
- Loaded with seed on start; a seed of 0 is replaced by 32'h1.
- Each message word is the current state; the LFSR advances once per word consumed.
- For DW=64, the upper half takes the current state and the lower half the next state, so the LFSR advances 2 per beat.
- Trailing invalid bytes are masked to 0.

Counters: beat and byte counters are LEN_W wide. The maximum length 2^LEN_W-1 must complete without overflow.

Test Plan:
1. DW=32, len=3, pttrn_sel=0, seed=0x61, rdy=1 -> one beat: d=32'h61626300, bvld=4'b1110, lst=1; done one cycle after acceptance.
2. DW=32, len=64, seed=0x00, rdy=1, gap=0 -> 16 consecutive beats: first d=32'h00010203, last d=32'h3C3D3E3F with lst=1, bvld=4'hF on all beats.
3. Same as 2, rdy forced low for 5 cycles at beat 7 -> beat 7 data/lst held unchanged for all 5 cycles; total beats still 16; no duplication or skip.
4. len=0 -> no vld ever asserted; done pulses at start+1; busy high for exactly one cycle.
5. DW=64, len=9, pttrn_sel=1, seed=0, gap_cyc=2 -> 2 beats separated by exactly 2 vld-low cycles; beat 0 = {32'h1, LFSR(1)}; beat 1 has bvld=8'h80, low 7 bytes zero, lst=1.
6. Reset asserted during beat 4 of a 64-byte message, then start with len=5 -> all outputs 0 during reset; new message starts clean with pattern restarted from seed.
